// File: rtl/stopwatch_main_pkg.sv
// Shared types and constants for the SS.hh stopwatch: BCD digit type, run states,
// and active-low 7-segment patterns ({dp,g,f,e,d,c,b,a}, dp off).
package stopwatch_main_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_state_t;

  localparam int NDIGITS = 4;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Decimal increment of a single digit; 9 rolls over to 0.
  function automatic bcd_t bcd_inc(input bcd_t d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/stopwatch_main_if.sv
// Board-side signal bundle of the stopwatch: control levels in, anode/segment lines out.
interface stopwatch_main_if;
  import stopwatch_main_pkg::*;

  logic       start;
  logic       stop;
  logic       inc;
  logic       dispen;
  logic [3:0] an;
  logic [7:0] seg;

  modport master (output start, stop, inc, dispen, input an, seg);
  modport slave  (input start, stop, inc, dispen, output an, seg);

endinterface

// File: rtl/stopwatch_main_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern, with decimal point control.
module seg7_decode
  import stopwatch_main_pkg::*;
(
  input  bcd_t       digit,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] code;

  always_comb begin
    code = SEG_BLANK;
    case (digit)
      4'd0:    code = SEG_0;
      4'd1:    code = SEG_1;
      4'd2:    code = SEG_2;
      4'd3:    code = SEG_3;
      4'd4:    code = SEG_4;
      4'd5:    code = SEG_5;
      4'd6:    code = SEG_6;
      4'd7:    code = SEG_7;
      4'd8:    code = SEG_8;
      4'd9:    code = SEG_9;
      default: code = SEG_BLANK;
    endcase
  end

  assign seg = {~dp, code[6:0]};

endmodule

// File: rtl/stopwatch_main.sv
// 4-digit SS.hh stopwatch: run FSM, step prescaler, BCD counter chain and a
// free-running multiplexed 7-segment scan with registered anode/segment outputs.
module stopwatch_main
  import stopwatch_main_pkg::*;
#(
  parameter int TICK_DIV = 1_000_000,
  parameter int FAST_DIV = 100_000,
  parameter int SCAN_DIV = 100_000
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_main_if.slave  io
);

  localparam int MAXDIV = (TICK_DIV > FAST_DIV) ? TICK_DIV : FAST_DIV;
  localparam int PW     = $clog2(MAXDIV + 1);
  localparam int SW     = $clog2(SCAN_DIV + 1);

  localparam logic [PW-1:0] TICK_LIM = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] FAST_LIM = PW'(FAST_DIV - 1);
  localparam logic [SW-1:0] SCAN_LIM = SW'(SCAN_DIV - 1);

  run_state_t    state;
  run_state_t    state_nxt;
  logic          running;
  logic [PW-1:0] presc;
  logic [PW-1:0] lim;
  logic          step;
  bcd_t          dig     [NDIGITS];
  bcd_t          dig_nxt [NDIGITS];
  logic          carry;
  logic [SW-1:0] sc;
  logic [1:0]    slot;
  bcd_t          cur_digit;
  logic          dp_on;
  logic [7:0]    seg_pat;
  logic [3:0]    an_p1;
  logic [7:0]    seg_p1;

  always_ff @(posedge clk) begin
    if (!rst) state <= STOPPED;
    else      state <= state_nxt;
  end

  // stop dominates start; neither asserted holds the current state
  always_comb begin
    state_nxt = state;
    if (io.stop)       state_nxt = STOPPED;
    else if (io.start) state_nxt = RUNNING;
  end

  assign running = (state == RUNNING);

  // A limit below the current prescaler value (inc raised mid-period) fires at once.
  assign lim  = io.inc ? FAST_LIM : TICK_LIM;
  assign step = running && (presc >= lim);

  always_ff @(posedge clk) begin
    if (!rst)         presc <= '0;
    else if (running) presc <= step ? '0 : presc + 1'b1;
  end

  always_comb begin
    carry = 1'b1;
    for (int i = 0; i < NDIGITS; i++) begin
      dig_nxt[i] = dig[i];
      if (carry) begin
        dig_nxt[i] = bcd_inc(dig[i]);
        carry      = (dig[i] >= 4'd9);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NDIGITS; i++) dig[i] <= '0;
    end else if (step) begin
      for (int i = 0; i < NDIGITS; i++) dig[i] <= dig_nxt[i];
    end
  end

  // Scan slots run regardless of run state or display enable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sc   <= '0;
      slot <= '0;
    end else if (sc >= SCAN_LIM) begin
      sc   <= '0;
      slot <= slot + 2'd1;
    end else begin
      sc   <= sc + 1'b1;
    end
  end

  assign cur_digit = dig[slot];
  assign dp_on     = (slot == 2'd2);

  seg7_decode u_dec (
    .digit (cur_digit),
    .dp    (dp_on),
    .seg   (seg_pat)
  );

  // output stage: anode and segment lines change on the same edge
  always_ff @(posedge clk) begin
    if (io.dispen) begin
      an_p1  <= ~(4'b0001 << slot);
      seg_p1 <= seg_pat;
    end else begin
      an_p1  <= 4'hF;
      seg_p1 <= SEG_BLANK;
    end
  end

  assign io.an  = an_p1;
  assign io.seg = seg_p1;

endmodule

// File: tb/tb_stopwatch_main.sv
// Bench for stopwatch_main: scenario tasks plus random control traffic, checked
// cycle by cycle against an integer-count reference model of the stopwatch.
module tb_stopwatch_main;

  localparam int TICK_DIV = 10;
  localparam int FAST_DIV = 1;
  localparam int SCAN_DIV = 4;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  stopwatch_main_if sif ();

  stopwatch_main #(
    .TICK_DIV (TICK_DIV),
    .FAST_DIV (FAST_DIV),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (sif)
  );

  int total = 0;
  int bad   = 0;

  // reference model: count as an integer 0..9999, slot derived from a cycle counter
  bit         m_run   = 1'b0;
  int         m_presc = 0;
  int         m_cnt   = 0;
  int         m_scan  = 0;
  logic [3:0] exp_an;
  logic [7:0] exp_seg;

  function automatic logic [7:0] seg_code(input int d, input bit dp);
    logic [7:0] tbl [10];
    logic [7:0] c;
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    c = tbl[d];
    if (dp) c[7] = 1'b0;
    return c;
  endfunction

  function automatic int digit_of(input int c, input int k);
    int p;
    p = 1;
    for (int j = 0; j < k; j++) p = p * 10;
    return (c / p) % 10;
  endfunction

  always @(posedge clk) begin
    int  sl;
    int  lim;
    bit  stp;
    sl = m_scan / SCAN_DIV;
    if (sif.dispen) begin
      exp_an  <= ~(4'b0001 << sl);
      exp_seg <= seg_code(digit_of(m_cnt, sl), sl == 2);
    end else begin
      exp_an  <= 4'hF;
      exp_seg <= 8'hFF;
    end
    if (!rst) begin
      m_run   <= 1'b0;
      m_presc <= 0;
      m_cnt   <= 0;
      m_scan  <= 0;
    end else begin
      lim = sif.inc ? FAST_DIV - 1 : TICK_DIV - 1;
      stp = m_run && (m_presc >= lim);
      if (m_run) m_presc <= stp ? 0 : m_presc + 1;
      if (stp)   m_cnt   <= (m_cnt + 1) % 10000;
      m_run  <= sif.stop ? 1'b0 : (sif.start ? 1'b1 : m_run);
      m_scan <= (m_scan + 1) % SCAN_CYC;
    end
  end

  task automatic test_reset();
    logic [7:0] want [4];
    logic [7:0] w;
    rst = 1'b0;
    sif.start = 1'b0; sif.stop = 1'b0; sif.inc = 1'b0; sif.dispen = 1'b1;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sif.an !== 4'b1110 || sif.seg !== 8'hC0) begin
      bad++;
      $display("FAIL reset_out an=%b seg=%h want an=1110 seg=c0", sif.an, sif.seg);
    end
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      total++;
      if (sif.an !== exp_an || sif.seg !== exp_seg) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d an=%b seg=%h want an=%b seg=%h", i, sif.an, sif.seg, exp_an, exp_seg);
      end
    end
    want = '{8'hC0, 8'hC0, 8'h40, 8'hC0};
    for (int i = 0; i < SCAN_CYC; i++) begin
      @(negedge clk);
      case (sif.an)
        4'b1110: w = want[0];
        4'b1101: w = want[1];
        4'b1011: w = want[2];
        4'b0111: w = want[3];
        default: w = 8'h00;
      endcase
      total++;
      if (sif.seg !== w || sif.an === 4'hF) begin
        bad++;
        $display("FAIL reset_digits an=%b seg=%h want seg=%h", sif.an, sif.seg, w);
      end
    end
  endtask

  task automatic test_run_normal();
    logic [7:0] want [4];
    logic [7:0] w;
    sif.start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if (sif.an !== exp_an || sif.seg !== exp_seg) begin
        bad++;
        $display("FAIL run_normal cyc=%0d an=%b seg=%h want an=%b seg=%h", i, sif.an, sif.seg, exp_an, exp_seg);
      end
    end
    sif.start = 1'b0;
    sif.stop  = 1'b1;
    @(negedge clk);
    sif.stop = 1'b0;
    @(negedge clk);
    want = '{8'hC0, 8'hF9, 8'h40, 8'hC0};
    for (int i = 0; i < 2 * SCAN_CYC; i++) begin
      @(negedge clk);
      case (sif.an)
        4'b1110: w = want[0];
        4'b1101: w = want[1];
        4'b1011: w = want[2];
        4'b0111: w = want[3];
        default: w = 8'h00;
      endcase
      total++;
      if (sif.seg !== w || sif.an === 4'hF) begin
        bad++;
        $display("FAIL run_normal_0010 an=%b seg=%h want seg=%h", sif.an, sif.seg, w);
      end
    end
  endtask

  task automatic test_fast_and_freeze();
    sif.inc   = 1'b1;
    sif.start = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      total++;
      if (sif.an !== exp_an || sif.seg !== exp_seg) begin
        bad++;
        $display("FAIL fast_run cyc=%0d an=%b seg=%h want an=%b seg=%h", i, sif.an, sif.seg, exp_an, exp_seg);
      end
    end
    sif.start = 1'b0;
    sif.stop  = 1'b1;
    @(negedge clk);
    sif.stop = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      total++;
      if (sif.an !== exp_an || sif.seg !== exp_seg) begin
        bad++;
        $display("FAIL fast_frozen cyc=%0d an=%b seg=%h want an=%b seg=%h", i, sif.an, sif.seg, exp_an, exp_seg);
      end
    end
  endtask

  task automatic test_start_stop_both();
    sif.inc   = 1'b0;
    sif.start = 1'b1;
    sif.stop  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      total++;
      if (sif.an !== exp_an || sif.seg !== exp_seg) begin
        bad++;
        $display("FAIL both_high cyc=%0d an=%b seg=%h want an=%b seg=%h", i, sif.an, sif.seg, exp_an, exp_seg);
      end
    end
    sif.start = 1'b0;
    sif.stop  = 1'b0;
  endtask

  task automatic test_wrap();
    logic [7:0] want [4];
    logic [7:0] w;
    bit         hit;
    hit = 1'b0;
    sif.inc   = 1'b1;
    sif.start = 1'b1;
    for (int i = 0; i < 20000 && !hit; i++) begin
      @(negedge clk);
      sif.start = 1'b0;
      total++;
      if (sif.an !== exp_an || sif.seg !== exp_seg) begin
        bad++;
        if (bad < 20)
          $display("FAIL wrap_climb cyc=%0d an=%b seg=%h want an=%b seg=%h", i, sif.an, sif.seg, exp_an, exp_seg);
      end
      if (m_cnt == 9998) begin
        sif.stop = 1'b1;
        hit = 1'b1;
      end
    end
    if (!hit) begin
      bad++;
      $display("FAIL wrap_timeout count did not reach 99.98 (model=%0d)", m_cnt);
    end
    @(negedge clk);
    sif.stop = 1'b0;
    @(negedge clk);
    want = '{8'h90, 8'h90, 8'h10, 8'h90};
    for (int i = 0; i < SCAN_CYC; i++) begin
      @(negedge clk);
      case (sif.an)
        4'b1110: w = want[0];
        4'b1101: w = want[1];
        4'b1011: w = want[2];
        4'b0111: w = want[3];
        default: w = 8'h00;
      endcase
      total++;
      if (sif.seg !== w || sif.an === 4'hF) begin
        bad++;
        $display("FAIL wrap_9999 an=%b seg=%h want seg=%h", sif.an, sif.seg, w);
      end
    end
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    sif.stop  = 1'b1;
    @(negedge clk);
    sif.stop = 1'b0;
    @(negedge clk);
    want = '{8'hC0, 8'hC0, 8'h40, 8'hC0};
    for (int i = 0; i < 2 * SCAN_CYC; i++) begin
      @(negedge clk);
      case (sif.an)
        4'b1110: w = want[0];
        4'b1101: w = want[1];
        4'b1011: w = want[2];
        4'b0111: w = want[3];
        default: w = 8'h00;
      endcase
      total++;
      if (sif.seg !== w || sif.an === 4'hF) begin
        bad++;
        $display("FAIL wrap_0000 an=%b seg=%h want seg=%h", sif.an, sif.seg, w);
      end
    end
    sif.inc = 1'b0;
  endtask

  task automatic test_dispen_and_midrun_reset();
    logic [7:0] want [4];
    logic [7:0] w;
    sif.start = 1'b1;
    @(negedge clk);
    sif.start  = 1'b0;
    sif.dispen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      total++;
      if (sif.an !== 4'hF || sif.seg !== 8'hFF) begin
        bad++;
        $display("FAIL dispen_off cyc=%0d an=%b seg=%h want an=1111 seg=ff", i, sif.an, sif.seg);
      end
    end
    sif.dispen = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if (sif.an !== exp_an || sif.seg !== exp_seg) begin
        bad++;
        $display("FAIL dispen_on cyc=%0d an=%b seg=%h want an=%b seg=%h", i, sif.an, sif.seg, exp_an, exp_seg);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    total++;
    if (sif.an !== 4'b1110 || sif.seg !== 8'hC0) begin
      bad++;
      $display("FAIL midrun_reset an=%b seg=%h want an=1110 seg=c0", sif.an, sif.seg);
    end
    want = '{8'hC0, 8'hC0, 8'h40, 8'hC0};
    for (int i = 0; i < 8 * SCAN_CYC; i++) begin
      @(negedge clk);
      case (sif.an)
        4'b1110: w = want[0];
        4'b1101: w = want[1];
        4'b1011: w = want[2];
        4'b0111: w = want[3];
        default: w = 8'h00;
      endcase
      total++;
      if (sif.seg !== w || sif.an === 4'hF) begin
        bad++;
        $display("FAIL reset_stopped an=%b seg=%h want seg=%h", sif.an, sif.seg, w);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      total++;
      if (sif.an !== exp_an || sif.seg !== exp_seg) begin
        bad++;
        if (bad < 20)
          $display("FAIL random cyc=%0d an=%b seg=%h want an=%b seg=%h", i, sif.an, sif.seg, exp_an, exp_seg);
      end
      sif.start = ($urandom_range(0, 15) == 0);
      sif.stop  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 40) == 0) sif.inc = ~sif.inc;
      sif.dispen = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 599) != 0);
    end
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_run_normal();
    test_fast_and_freeze();
    test_start_stop_both();
    test_wrap();
    test_dispen_and_midrun_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
